// File: rtl/pe_ctrl_pkg.sv
// Shared types and default sizing for the PE output collection path.
package pe_ctrl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } pe_state_t;

  localparam int DEF_GROUP_SIZE  = 4;
  localparam int DEF_BLOCK_COUNT = 4;
  localparam int DEF_DATA_WIDTH  = 16;

endpackage

// File: rtl/pe_wrap_counter.sv
// Enabled up-counter with synchronous active-low clear that wraps to zero after LIMIT.
module pe_wrap_counter #(
  parameter int               WIDTH = 2,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             clk,
  input  logic             sclr_n,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LIMIT) ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/pe_output_collector.sv
// Captures a full PE result group and serialises it one element per accepted beat,
// tracking element and block position within a frame.
module pe_output_collector
  import pe_ctrl_pkg::*;
#(
  parameter int O_PEGroupSize   = DEF_GROUP_SIZE,
  parameter int O_PEAddrWidth   = 2,
  parameter int BlockCount      = DEF_BLOCK_COUNT,
  parameter int BlockCountWidth = 3,
  parameter int DataWidth       = DEF_DATA_WIDTH
) (
  input  logic                               clk,
  input  logic                               sclr_n,
  input  logic                               PE_Valid,
  input  logic [O_PEGroupSize*DataWidth-1:0] PE_Data,
  output logic                               PE_Ready,
  output logic                               Out_Valid,
  input  logic                               Out_Ready,
  output logic [DataWidth-1:0]               Out_Data,
  output logic [O_PEAddrWidth-1:0]           Out_Addr,
  output logic [BlockCountWidth-1:0]         Out_Block,
  output logic                               Out_Last,
  output logic                               Frame_Done,
  output logic                               BLOCK_EQUAL_TO_ZERO,
  output logic                               BLOCK_EQUAL_TO_BLOCK_COUNT
);

  localparam logic [O_PEAddrWidth-1:0]   ELEM_LAST = O_PEAddrWidth'(O_PEGroupSize - 1);
  localparam logic [BlockCountWidth-1:0] BLK_LAST  = BlockCountWidth'(BlockCount - 1);

  pe_state_t                                state_p0;
  logic [O_PEGroupSize-1:0][DataWidth-1:0]  grp_p0;
  logic [O_PEAddrWidth-1:0]                 elem_ptr;
  logic [BlockCountWidth-1:0]               blk_cnt;
  logic                                     beat;
  logic                                     elem_last;
  logic                                     group_done;

  assign elem_last  = (elem_ptr == ELEM_LAST);
  assign Out_Valid  = sclr_n && (state_p0 == DRAIN);
  assign beat       = Out_Valid && Out_Ready;
  assign group_done = beat && elem_last;
  // A group may be refilled on the same edge its last element leaves, so no bubble.
  assign PE_Ready   = sclr_n && ((state_p0 == IDLE) || group_done);

  pe_wrap_counter #(
    .WIDTH (O_PEAddrWidth),
    .LIMIT (ELEM_LAST)
  ) u_elem_cnt (
    .clk    (clk),
    .sclr_n (sclr_n),
    .en     (beat),
    .count  (elem_ptr)
  );

  pe_wrap_counter #(
    .WIDTH (BlockCountWidth),
    .LIMIT (BLK_LAST)
  ) u_blk_cnt (
    .clk    (clk),
    .sclr_n (sclr_n),
    .en     (group_done),
    .count  (blk_cnt)
  );

  // Stage p0: group capture, state, and frame completion pulse.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state_p0   <= IDLE;
      grp_p0     <= '0;
      Frame_Done <= 1'b0;
    end else begin
      Frame_Done <= beat && Out_Last;
      case (state_p0)
        IDLE: begin
          if (PE_Valid) begin
            grp_p0   <= PE_Data;
            state_p0 <= DRAIN;
          end
        end
        DRAIN: begin
          if (group_done) begin
            if (PE_Valid) begin
              grp_p0 <= PE_Data;
            end else begin
              state_p0 <= IDLE;
            end
          end
        end
        default: state_p0 <= IDLE;
      endcase
    end
  end

  assign Out_Data                   = grp_p0[elem_ptr];
  assign Out_Addr                   = elem_ptr;
  assign Out_Block                  = blk_cnt;
  assign Out_Last                   = Out_Valid && elem_last && (blk_cnt == BLK_LAST);
  assign BLOCK_EQUAL_TO_ZERO        = (blk_cnt == '0);
  assign BLOCK_EQUAL_TO_BLOCK_COUNT = (blk_cnt == BLK_LAST);

endmodule

// File: doc/pe_output_collector.md
PE_OUTPUT_COLLECTOR -- requirements
Module: pe_output_collector

Interface
REQ-001 Parameter O_PEGroupSize, 4, number of PE results per output group.
REQ-002 Parameter O_PEAddrWidth, 2, width of the element pointer; 2^O_PEAddrWidth SHALL be >= O_PEGroupSize.
REQ-003 Parameter BlockCount, 4, groups per frame.
REQ-004 Parameter BlockCountWidth, 3, width of the block counter; SHALL hold BlockCount-1.
REQ-005 Parameter DataWidth, 16, width of one PE result.
REQ-006 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-007 sclr_n  in  1  synchronous reset, active-low, sampled on the clk rising edge.
REQ-008 PE_Valid  in  1  PE group presents a complete result group.
REQ-009 PE_Data  in  O_PEGroupSize*DataWidth  group results; element 0 in the least-significant DataWidth bits.
REQ-010 PE_Ready  out  1  collector accepts the group this cycle.
REQ-011 Out_Valid  out  1  Out_Data/Out_Addr/Out_Block are valid.
REQ-012 Out_Ready  in  1  output buffer accepts the current element.
REQ-013 Out_Data  out  DataWidth  current element.
REQ-014 Out_Addr  out  O_PEAddrWidth  element index within the group.
REQ-015 Out_Block  out  BlockCountWidth  block index within the frame.
REQ-016 Out_Last  out  1  current element is the final element of the frame.
REQ-017 Frame_Done  out  1  one-cycle pulse after the frame's final element is accepted.
REQ-018 BLOCK_EQUAL_TO_ZERO, BLOCK_EQUAL_TO_BLOCK_COUNT  out  1 each  block counter ==0 / ==BlockCount-1.

Function
REQ-019 The FSM SHALL have two states: IDLE (no group held) and DRAIN (group held, elements being emitted).
REQ-020 PE_Ready SHALL be 1 in IDLE, and 1 in DRAIN only when Out_Valid, Out_Ready and Elem_Ptr==O_PEGroupSize-1 all hold; otherwise 0.
REQ-021 On PE_Valid && PE_Ready, PE_Data SHALL be latched into the group register, Elem_Ptr SHALL become 0 and the state SHALL become DRAIN; the first element SHALL appear on Out_Data the next cycle (latency 1).
REQ-022 In DRAIN, Out_Valid SHALL be 1, with Out_Data = element Elem_Ptr, Out_Addr = Elem_Ptr, and Out_Block = block counter.
REQ-023 While Out_Valid && !Out_Ready, Out_Data, Out_Addr and Out_Block SHALL hold stable.
REQ-024 On Out_Ready when Elem_Ptr < O_PEGroupSize-1, Elem_Ptr SHALL increment by 1.
REQ-025 On Out_Ready at Elem_Ptr==O_PEGroupSize-1:
- Elem_Ptr SHALL wrap to 0.
- The block counter SHALL increment, wrapping to 0 at BlockCount-1.
- The state SHALL go to IDLE, unless PE_Valid is high in the same cycle; then the new group SHALL be captured and the state SHALL stay DRAIN (back-to-back, no bubble).
REQ-026 Out_Last SHALL equal Out_Valid && Elem_Ptr==O_PEGroupSize-1 && block counter==BlockCount-1.
REQ-027 Frame_Done SHALL be registered, high for exactly one cycle following the cycle in which Out_Last && Out_Ready.
REQ-028 In IDLE, Out_Valid SHALL be 0 and PE_Valid deassertion SHALL have no effect.
REQ-029 Counter arithmetic SHALL be unsigned, and the block counter SHALL never reach BlockCount.

Reset
REQ-030 With sclr_n low at a clk edge:
- The state SHALL become IDLE.
- Elem_Ptr, the block counter, the group register and Frame_Done SHALL become 0.
REQ-031 While sclr_n is low, PE_Ready and Out_Valid SHALL be driven 0.
REQ-032 A reset asserted mid-DRAIN SHALL discard the held group and partial frame, with no Frame_Done pulse.
REQ-033 After reset, BLOCK_EQUAL_TO_ZERO SHALL be 1.

Structure
REQ-034 The shared package pe_ctrl_pkg SHALL hold the FSM state type (IDLE, DRAIN) and the default values of O_PEGroupSize, BlockCount and DataWidth.
REQ-035 The wrapping counter (enable, sync active-low reset, wrap at a limit) SHALL be one sub-module, pe_wrap_counter, instantiated twice: once for Elem_Ptr and once for the block counter.

Verification
REQ-036 Single group: after reset, PE_Valid=1 with PE_Data={16'h0004,16'h0003,16'h0002,16'h0001} and Out_Ready=1 -> Out_Data 1,2,3,4 on consecutive cycles, Out_Addr 0..3, Out_Block 0, then IDLE and BLOCK_EQUAL_TO_ZERO=0.
REQ-037 Backpressure: Out_Ready held 0 for 3 cycles at element 2 -> Out_Data=3 and Out_Addr=2 stay stable, and PE_Ready=0 throughout.
REQ-038 Back-to-back: PE_Valid held 1 with Out_Ready=1 for 4 groups -> 16 contiguous Out_Valid cycles with no bubble; Out_Last only on the 16th; Frame_Done high on the 17th cycle only; block counter back to 0.
REQ-039 Block wrap: 5 groups -> fifth group emitted with Out_Block=0 and BLOCK_EQUAL_TO_ZERO=1.
REQ-040 Reset mid-operation: sclr_n low during block 3, element 1 -> next cycle Out_Valid=0, PE_Ready=0, counters 0, no Frame_Done; after release, a new group is emitted with Out_Block=0.
